// File: rtl/cmd_dispatch_if.sv
// Command dispatcher bus: packet strobe, opcode and per-channel busy flags in,
// issue pulses, queue status and error pulses out.
interface cmd_dispatch_if #(
   parameter int N_CMD  = 8,
   parameter int OPC_W  = 8,
   parameter int QDEPTH = 4
);
   logic                       packet_ready;
   logic [OPC_W-1:0]           opcode;
   logic [N_CMD-1:0]           BUSY;
   logic [N_CMD-1:0]           CMD;
   logic [$clog2(QDEPTH):0]    q_count;
   logic                       q_full;
   logic                       err_unknown;
   logic                       err_drop;
   logic                       err_timeout;

   modport master (
      output packet_ready, opcode, BUSY,
      input  CMD, q_count, q_full, err_unknown, err_drop, err_timeout
   );

   modport slave (
      input  packet_ready, opcode, BUSY,
      output CMD, q_count, q_full, err_unknown, err_drop, err_timeout
   );
endinterface

// File: rtl/cmd_dispatch.sv
// Gated command dispatcher: decodes opcodes to channels, issues immediately when
// the channel gate allows, otherwise queues in order with a head-of-line timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_EMPTY  | queue empty, no issue or expiry happened last cycle
// S_WAIT   | queue non-empty, head waiting on its gate
// S_ISSUE  | a command was issued last cycle; CMD pulse is on the outputs
// S_EXPIRE | the head timed out last cycle; err_timeout is on the outputs
module cmd_dispatch #(
   parameter int               N_CMD     = 8,
   parameter int               OPC_W     = 8,
   parameter int               QDEPTH    = 4,
   parameter int               TIMEOUT   = 16,
   parameter logic [N_CMD-1:0] IDLE_MASK = 8'hD6,
   parameter logic [N_CMD-1:0] CONT_MASK = 8'h28
) (
   input logic           CLK,
   input logic           rst,
   cmd_dispatch_if.slave bus
);
   localparam int CH_W  = (N_CMD > 1) ? $clog2(N_CMD) : 1;
   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WC_W  = $clog2(TIMEOUT + 2);

   typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_ISSUE, S_EXPIRE} state_t;

   state_t            state, state_next;
   logic [CH_W-1:0]   mem [QDEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count, count_next;
   logic [WC_W-1:0]   wait_cnt, wait_next;
   logic [CH_W-1:0]   iss_ch, iss_next;
   logic              q_full_r, err_unk_r, err_drop_r;

   logic [N_CMD-1:0]  gate;
   logic [CH_W-1:0]   head, pkt_ch;
   logic              q_empty, q_full_now, pkt_valid, unknown;
   logic              head_go, expire, pop, bypass, push, drop;

   // Gate is evaluated on this cycle's BUSY; channel 0 has no lower neighbour.
   for (genvar c = 0; c < N_CMD; c++) begin : g_gate
      if (c == 0) begin : g_first
         assign gate[c] = IDLE_MASK[c] ? !bus.BUSY[c] : 1'b1;
      end else begin : g_rest
         assign gate[c] = IDLE_MASK[c] ? !bus.BUSY[c] :
                          CONT_MASK[c] ? bus.BUSY[c-1] : 1'b1;
      end
   end

   always_comb begin
      head       = mem[rd_ptr];
      q_empty    = (count == '0);
      q_full_now = (count == CNT_W'(QDEPTH));
      pkt_valid  = bus.packet_ready && (bus.opcode != '0) &&
                   (bus.opcode <= OPC_W'(N_CMD));
      unknown    = bus.packet_ready && !pkt_valid;
      pkt_ch     = CH_W'(bus.opcode - OPC_W'(1));

      head_go = !q_empty && gate[head];
      expire  = !q_empty && !gate[head] && (TIMEOUT != 0) &&
                (wait_cnt == WC_W'(TIMEOUT - 1));
      pop     = head_go || expire;
      bypass  = pkt_valid && q_empty && gate[pkt_ch];
      push    = pkt_valid && !bypass && (!q_full_now || pop);
      drop    = pkt_valid && !bypass && q_full_now && !pop;

      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase

      wait_next = wait_cnt;
      if (pop || q_empty)
         wait_next = '0;
      else if (TIMEOUT != 0)
         wait_next = wait_cnt + WC_W'(1);

      iss_next = iss_ch;
      if (head_go)
         iss_next = head;
      else if (bypass)
         iss_next = pkt_ch;

      state_next = state;
      if (head_go || bypass)
         state_next = S_ISSUE;
      else if (expire)
         state_next = S_EXPIRE;
      else if (count_next == '0)
         state_next = S_EMPTY;
      else
         state_next = S_WAIT;
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state      <= S_EMPTY;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         wait_cnt   <= '0;
         iss_ch     <= '0;
         q_full_r   <= 1'b0;
         err_unk_r  <= 1'b0;
         err_drop_r <= 1'b0;
      end else begin
         state      <= state_next;
         count      <= count_next;
         wait_cnt   <= wait_next;
         iss_ch     <= iss_next;
         q_full_r   <= (count_next == CNT_W'(QDEPTH));
         err_unk_r  <= unknown;
         err_drop_r <= drop;
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
      end
   end

   // Storage needs no reset: pointers and count define which entries are live.
   // When full with a same-cycle pop, wr_ptr==rd_ptr and the head is read before overwrite.
   always_ff @(posedge CLK) begin
      if (!rst && push)
         mem[wr_ptr] <= pkt_ch;
   end

   assign bus.CMD         = (state == S_ISSUE) ? (N_CMD'(1) << iss_ch) : '0;
   assign bus.err_timeout = (state == S_EXPIRE);
   assign bus.err_unknown = err_unk_r;
   assign bus.err_drop    = err_drop_r;
   assign bus.q_count     = count;
   assign bus.q_full      = q_full_r;
endmodule

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 N_CMD, 8, number of command channels; opcode k (1..N_CMD) selects channel k-1.
REQ-002 OPC_W, 8, opcode width.
REQ-003 QDEPTH, 4, pending-command queue depth (power of two, >=2).
REQ-004 TIMEOUT, 16, consecutive blocked cycles before the queue head is discarded; 0 disables the timeout.
REQ-005 IDLE_MASK, 8'hD6, bit c=1: channel c issues only when BUSY[c]=0.
REQ-006 CONT_MASK, 8'h28, bit c=1: channel c issues only when BUSY[c-1]=1; channel 0 bit ignored; IDLE_MASK and CONT_MASK bits never both set.
REQ-007 CLK  in  1  sole clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 packet_ready  in  1  one-cycle strobe: opcode valid this cycle.
REQ-010 opcode  in  OPC_W  command code.
REQ-011 BUSY  in  N_CMD  per-channel engine busy flags.
REQ-012 CMD  out  N_CMD  registered one-hot issue pulse, one cycle wide.
REQ-013 q_count  out  clog2(QDEPTH)+1  registered queue occupancy.
REQ-014 q_full  out  1  q_count==QDEPTH.
REQ-015 err_unknown / err_drop / err_timeout  out  1 each  registered one-cycle error pulses.

Function
REQ-016 Gate(c) SHALL be: IDLE_MASK[c] ? !BUSY[c] : CONT_MASK[c] ? BUSY[c-1] : 1, evaluated on current-cycle BUSY.
REQ-017 Opcode 0 or >N_CMD with packet_ready SHALL pulse err_unknown next cycle; nothing enqueued or issued.
REQ-018 Queue SHALL be in-order FIFO of channel indices; only the head may issue; at most one CMD bit high per cycle.
REQ-019 Queue empty, valid packet, Gate true: SHALL bypass queue, CMD[c]=1 on cycle t+1 (1-cycle latency).
REQ-020 Queue empty, valid packet, Gate false: SHALL enqueue; q_count=1 at t+1.
REQ-021 Queue non-empty: valid packet SHALL enqueue behind head (no bypass), regardless of its Gate.
REQ-022 Head with Gate true SHALL pop and pulse CMD[head] next cycle.
REQ-023 Simultaneous pop and push SHALL both take effect, q_count unchanged, including when full.
REQ-024 Push while full with no same-cycle pop SHALL drop the packet and pulse err_drop next cycle; queue unchanged.
REQ-025 Wait counter SHALL increment each cycle the head is present and blocked, clear on any pop or when queue empty.
REQ-026 When counter reaches TIMEOUT, head SHALL pop without CMD, err_timeout pulses next cycle, counter clears.
REQ-027 Pointers SHALL wrap modulo QDEPTH; q_count never exceeds QDEPTH nor underflows.
REQ-028 State machine per head: EMPTY (q_count=0) -> WAIT (head blocked) -> ISSUE (Gate true, pop) or EXPIRE (timeout, pop); after pop return WAIT if entries remain, else EMPTY.
REQ-029 Unknown-opcode and drop conditions in same cycle are exclusive (unknown takes precedence; unknown never counted as drop).

Reset
REQ-030 rst high SHALL, at the next edge, clear CMD, all err pulses, q_count, q_full, pointers, wait counter; pending entries discarded.
REQ-031 rst mid-operation SHALL override any pop, push or issue that cycle; no CMD pulse follows the reset edge.
REQ-032 First packet accepted on the cycle after rst deasserts.

Verification
REQ-033 BUSY=0, opcode 8'h01 strobe -> CMD=8'h01 exactly one cycle later, one cycle wide; q_count stays 0.
REQ-034 BUSY=8'h02, opcode 8'h02 -> q_count=1, no CMD; drop BUSY[1] at cycle 5 -> CMD=8'h02 at cycle 6, q_count=0.
REQ-035 BUSY=8'h04 held, opcodes 3,3,3,3,3 on consecutive cycles -> 4 enqueued, q_full=1, err_drop pulse on 5th; BUSY=0 -> four CMD=8'h04 pulses on consecutive cycles.
REQ-036 BUSY=0, opcode 8'h04 (CONT, needs BUSY[2]) held blocked -> err_timeout after 16 blocked cycles, no CMD, q_count 0.
REQ-037 opcode 8'h00 and 8'h09 -> err_unknown pulse each, CMD=0, q_count unchanged.
REQ-038 Queue holding 3 entries, rst asserted one cycle as head becomes issuable -> no CMD, q_count=0 after reset edge.
